// File: rtl/jfpjc_frame_sequencer_if.sv
// Output byte stream between the JPEG frame sequencer and its downstream sink.
// Plain valid/ready handshake; a byte moves when out_valid && out_ready.
interface jfpjc_frame_sequencer_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/jfpjc_frame_sequencer.sv
// JPEG frame sequencer: header ROM bytes, FIFO-buffered scan bytes, then EOI (FF D9).
// Optional macro JFPJC_FRAMER_BYTESTUFF_EN inserts 0x00 after every scan-data 0xFF.
module jfpjc_frame_sequencer #(
  parameter int HEADER_LEN = 328,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    frame_start,
  input  logic                    frame_end,
  input  logic                    comp_valid,
  input  logic [7:0]              comp_data,
  output logic [8:0]              header_addr,
  input  logic [7:0]              header_data,
  jfpjc_frame_sequencer_if.master out_if,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [8:0]    LAST_ADDR = 9'(HEADER_LEN - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SCAN,
    S_EOI_FF,
    S_EOI_D9
  } state_t;

  state_t      r_state;
  logic [8:0]  r_headerAddr;
  logic        r_hdrValid;
  logic        r_endLatch;
  logic        r_overflow;
  logic        r_frameDone;
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [7:0]  r_mem [FIFO_DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_xfer;
  logic        w_valid;
  logic        w_stuffActive;
  logic [7:0]  w_head;
  logic [7:0]  w_data;

`ifdef JFPJC_FRAMER_BYTESTUFF_EN
  logic r_stuffPending;
  assign w_stuffActive = r_stuffPending;
`else
  assign w_stuffActive = 1'b0;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_head   = r_mem[r_rdPtr[AW-1:0]];
  assign w_accept = comp_valid && ((r_state == S_HEADER) || (r_state == S_SCAN));
  assign w_push   = w_accept && !w_full;
  assign w_xfer   = w_valid && out_if.out_ready;
  assign w_pop    = (r_state == S_SCAN) && w_xfer && !w_stuffActive;

  // Output byte is decoded purely from registered state, so reset clears it at once.
  always_comb begin
    w_valid = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      S_HEADER: begin
        w_valid = r_hdrValid;
        w_data  = header_data;
      end
      S_SCAN: begin
        w_valid = !w_empty || w_stuffActive;
        w_data  = w_stuffActive ? 8'h00 : w_head;
      end
      S_EOI_FF: begin
        w_valid = 1'b1;
        w_data  = 8'hFF;
      end
      S_EOI_D9: begin
        w_valid = 1'b1;
        w_data  = 8'hD9;
      end
      default: begin
        w_valid = 1'b0;
        w_data  = 8'h00;
      end
    endcase
  end

  assign out_if.out_valid = w_valid;
  assign out_if.out_data  = w_data;
  assign header_addr      = r_headerAddr;
  assign busy             = (r_state != S_IDLE);
  assign frame_done       = r_frameDone;
  assign overflow         = r_overflow;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= comp_data;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_headerAddr <= 9'd0;
      r_hdrValid   <= 1'b0;
      r_endLatch   <= 1'b0;
      r_overflow   <= 1'b0;
      r_frameDone  <= 1'b0;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
`ifdef JFPJC_FRAMER_BYTESTUFF_EN
      r_stuffPending <= 1'b0;
`endif
    end else begin
      r_frameDone <= 1'b0;

      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_accept && w_full) begin
        r_overflow <= 1'b1;
      end
      if (frame_end && ((r_state == S_HEADER) || (r_state == S_SCAN))) begin
        r_endLatch <= 1'b1;
      end

`ifdef JFPJC_FRAMER_BYTESTUFF_EN
      // A transferred data 0xFF arms the stuff byte; the stuff byte's own transfer disarms it.
      if ((r_state == S_SCAN) && w_xfer) begin
        r_stuffPending <= !r_stuffPending && (w_head == 8'hFF);
      end
`endif

      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state      <= S_HEADER;
            r_headerAddr <= 9'd0;
            r_hdrValid   <= 1'b0;
            r_overflow   <= 1'b0;
            r_endLatch   <= 1'b0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
          end
        end
        S_HEADER: begin
          // The ROM is registered: each new address gets one idle cycle before its byte is shown.
          if (w_xfer) begin
            r_hdrValid <= 1'b0;
            if (r_headerAddr == LAST_ADDR) begin
              r_state <= S_SCAN;
            end else begin
              r_headerAddr <= r_headerAddr + 9'd1;
            end
          end else begin
            r_hdrValid <= 1'b1;
          end
        end
        S_SCAN: begin
          if (r_endLatch && w_empty && !w_stuffActive && !comp_valid) begin
            r_state <= S_EOI_FF;
          end
        end
        S_EOI_FF: begin
          if (w_xfer) begin
            r_state <= S_EOI_D9;
          end
        end
        S_EOI_D9: begin
          if (w_xfer) begin
            r_frameDone <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jfpjc_frame_sequencer.sv
// Self-checking bench for jfpjc_frame_sequencer: table-driven frames plus corner-case sequences.
// Expected stream bytes go into a scoreboard queue when driven and are popped as the DUT emits them.
module tb_jfpjc_frame_sequencer;

  localparam int HLEN  = 4;
  localparam int DEPTH = 16;

  logic       clock       = 1'b0;
  logic       nreset      = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end   = 1'b0;
  logic       comp_valid  = 1'b0;
  logic [7:0] comp_data   = 8'h00;
  logic [8:0] header_addr;
  logic [7:0] header_data;
  logic       busy;
  logic       frame_done;
  logic       overflow;
  logic [7:0] rom [4];

  jfpjc_frame_sequencer_if sif();

  int         nChecks    = 0;
  int         nFails     = 0;
  int         cycleCount = 0;
  int         outCount   = 0;
  logic [7:0] sbQ[$];
  int         xferCyc[$];

  typedef struct {
    int              n;
    logic [0:3][7:0] b;
    int              stall;
    int              expPlain;
    int              expStuff;
  } vec_t;

  vec_t vecs [4];

  jfpjc_frame_sequencer #(
    .HEADER_LEN(HLEN),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .comp_valid (comp_valid),
    .comp_data  (comp_data),
    .header_addr(header_addr),
    .header_data(header_data),
    .out_if     (sif),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Registered header ROM: data follows the address by one clock.
  always @(posedge clock) begin
    header_data <= rom[header_addr[1:0]];
    cycleCount  <= cycleCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every transferred byte is compared against the next scoreboard entry.
  always @(negedge clock) begin
    if (nreset && sif.out_valid && sif.out_ready) begin
      outCount++;
      xferCyc.push_back(cycleCount);
      if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected byte: actual %0h, required none (t=%0t)", sif.out_data, $time);
      end else begin
        checkOutput("stream byte", {24'h0, sif.out_data}, {24'h0, sbQ.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    for (int i = 0; i < HLEN; i++) sbQ.push_back(rom[i]);
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit push);
    comp_valid = 1'b1;
    comp_data  = b;
    if (push) begin
      sbQ.push_back(b);
`ifdef JFPJC_FRAMER_BYTESTUFF_EN
      if (b == 8'hFF) sbQ.push_back(8'h00);
`endif
    end
    tick(1);
    comp_valid = 1'b0;
  endtask

  task automatic endFrame();
    frame_end = 1'b1;
    sbQ.push_back(8'hFF);
    sbQ.push_back(8'hD9);
    tick(1);
    frame_end = 1'b0;
  endtask

  task automatic waitHeader();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (sbQ.size() == 0) break;
    end
    checkOutput("header drained", sbQ.size(), 0);
    tick(1);
  endtask

  task automatic waitDone(input int budget, input int expCount);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("frame_done pulse", {31'h0, seen}, 1);
    if (seen) begin
      checkOutput("busy with frame_done", {31'h0, busy}, 0);
      @(negedge clock);
      checkOutput("frame_done width", {31'h0, frame_done}, 0);
    end
    checkOutput("scoreboard drained", sbQ.size(), 0);
    checkOutput("output byte count", outCount, expCount);
    tick(1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int expCount;
`ifdef JFPJC_FRAMER_BYTESTUFF_EN
    expCount = v.expStuff;
`else
    expCount = v.expPlain;
`endif
    sif.out_ready = (v.stall == 0);
    outCount = 0;
    xferCyc.delete();
    startFrame();
    checkOutput("busy after start", {31'h0, busy}, 1);
    for (int i = 0; i < v.n; i++) sendByte(v.b[i], 1'b1);
    endFrame();
    if (v.stall > 0) begin
      tick(v.stall);
      sif.out_ready = 1'b1;
    end
    waitDone(200, expCount);
    checkOutput("overflow clear", {31'h0, overflow}, 0);
    if (v.stall == 0 && xferCyc.size() >= HLEN) begin
      for (int i = 1; i < HLEN; i++)
        checkOutput("header spacing", xferCyc[i] - xferCyc[i-1], 2);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rom[0] = 8'hFF; rom[1] = 8'hD8; rom[2] = 8'h12; rom[3] = 8'h34;
    sif.out_ready = 1'b0;

    vecs[0] = '{3, {8'h12, 8'hFF, 8'h34, 8'h00}, 0,  9, 10};
    vecs[1] = '{2, {8'hAA, 8'hBB, 8'h00, 8'h00}, 0,  8,  8};
    vecs[2] = '{4, {8'hFF, 8'hFF, 8'h00, 8'h7E}, 5, 10, 12};
    vecs[3] = '{0, {8'h00, 8'h00, 8'h00, 8'h00}, 0,  6,  6};

    #3;
    checkOutput("reset out_valid",   {31'h0, sif.out_valid}, 0);
    checkOutput("reset out_data",    {24'h0, sif.out_data},  0);
    checkOutput("reset busy",        {31'h0, busy},          0);
    checkOutput("reset header_addr", {23'h0, header_addr},   0);
    checkOutput("reset overflow",    {31'h0, overflow},      0);
    checkOutput("reset frame_done",  {31'h0, frame_done},    0);
    tick(3);
    nreset = 1'b1;
    tick(2);

    for (int v = 0; v < 4; v++) applyStimulus(vecs[v]);

    // Overflow: 17 bytes into a stalled 16-deep FIFO; the 17th must vanish.
    sif.out_ready = 1'b1;
    outCount = 0;
    startFrame();
    waitHeader();
    sif.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) sendByte(8'(8'h40 + i), 1'b1);
    checkOutput("no overflow at full", {31'h0, overflow}, 0);
    sendByte(8'h99, 1'b0);
    tick(1);
    checkOutput("overflow sticky", {31'h0, overflow}, 1);
    sif.out_ready = 1'b1;
    endFrame();
    waitDone(200, HLEN + DEPTH + 2);
    checkOutput("overflow held after frame", {31'h0, overflow}, 1);

    // frame_start mid-SCAN is ignored; a new frame_start clears the old overflow.
    outCount = 0;
    startFrame();
    checkOutput("overflow cleared by start", {31'h0, overflow}, 0);
    waitHeader();
    sendByte(8'hAA, 1'b1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    sendByte(8'hBB, 1'b1);
    checkOutput("busy after mid start", {31'h0, busy}, 1);
    endFrame();
    waitDone(200, 8);

    // Asynchronous reset in SCAN with queued bytes, then a clean frame from address 0.
    startFrame();
    waitHeader();
    sif.out_ready = 1'b0;
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    checkOutput("valid before reset", {31'h0, sif.out_valid}, 1);
    #2;
    nreset = 1'b0;
    #1;
    checkOutput("mid reset out_valid",   {31'h0, sif.out_valid}, 0);
    checkOutput("mid reset out_data",    {24'h0, sif.out_data},  0);
    checkOutput("mid reset busy",        {31'h0, busy},          0);
    checkOutput("mid reset header_addr", {23'h0, header_addr},   0);
    sbQ.delete();
    tick(2);
    nreset = 1'b1;
    sif.out_ready = 1'b1;
    tick(1);
    outCount = 0;
    startFrame();
    sendByte(8'h5A, 1'b1);
    endFrame();
    waitDone(200, HLEN + 3);
    checkOutput("overflow after reset frame", {31'h0, overflow}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/jfpjc_frame_sequencer.md
JFPJC_FRAME_SEQUENCER -- requirements
Module: jfpjc_frame_sequencer

Interface
REQ-001 SHALL have parameter HEADER_LEN, default 328, meaning the header byte count (SOI through SOS) read from the header ROM.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the scan-byte FIFO depth (power of 2).
REQ-003 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port frame_start, input, 1, a one-cycle pulse requesting a new JPEG frame.
REQ-006 SHALL have port frame_end, input, 1, a one-cycle pulse marking the compressor's last scan byte issued.
REQ-007 SHALL have port comp_valid, input, 1, the compressor byte strobe (no backpressure).
REQ-008 SHALL have port comp_data, input, 8, the compressor scan byte.
REQ-009 SHALL have port header_addr, output, 9, the header ROM address.
REQ-010 SHALL have port header_data, input, 8, the header ROM data, registered, valid 1 cycle after header_addr.
REQ-011 SHALL have port out_valid, output, 1, the output byte valid.
REQ-012 SHALL have port out_data, output, 8, the output byte.
REQ-013 SHALL have port out_ready, input, 1, the sink ready; transfer = out_valid && out_ready.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port frame_done, output, 1, a one-cycle pulse after the EOI transfer.
REQ-016 SHALL have port overflow, output, 1, a sticky FIFO overflow flag.

Function
REQ-017 SHALL implement states IDLE, HEADER, SCAN, EOI_FF, EOI_D9.
REQ-018 IDLE: on frame_start, go to HEADER with header_addr=0, clear overflow and the frame_end latch; in IDLE, comp_valid bytes are discarded without setting overflow.
REQ-019 HEADER: hold header_addr; assert out_valid once the address has been stable ≥1 cycle, with out_data=header_data; on transfer, increment header_addr and deassert out_valid for 1 cycle; giving 1 byte per 2 cycles at out_ready=1.
REQ-020 HEADER: after the transfer at header_addr=HEADER_LEN-1, go to SCAN.
REQ-021 In HEADER and SCAN, each comp_valid cycle writes comp_data to the FIFO; if the FIFO is full, drop the byte, set overflow, and leave FIFO contents unchanged.
REQ-022 SCAN: out_valid = FIFO non-empty or stuff pending; a byte written into an empty FIFO is presented on the next cycle; out_data = FIFO head; out_data is stable while out_valid && !out_ready.
REQ-023 Byte stuffing: on transfer of a 0xFF FIFO byte, set stuff_pending and present 0x00 next, before popping further; clear stuff_pending on its transfer.
REQ-024 A simultaneous FIFO write and pop SHALL both take effect, and occupancy SHALL remain unchanged.
REQ-025 frame_end in HEADER or SCAN SHALL set the frame_end latch; a comp_valid on the same cycle SHALL be accepted.
REQ-026 SCAN: when the frame_end latch is set, the FIFO is empty and no stuff is pending, go to EOI_FF.
REQ-027 EOI_FF SHALL present 0xFF and then go to EOI_D9 on transfer; EOI_D9 SHALL present 0xD9 and, on transfer, pulse frame_done and go to IDLE. The EOI 0xFF SHALL never be stuffed.
REQ-028 frame_start outside IDLE SHALL be ignored.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wrapping modulo 2·FIFO_DEPTH; full = MSBs differ and the rest are equal.

Reset
REQ-030 While nreset=0: state IDLE; FIFO empty; stuff_pending=0; frame_end latch=0; header_addr=0; out_valid, out_data, busy, frame_done and overflow all 0.
REQ-031 Reset mid-frame SHALL abandon the frame; the next frame SHALL restart from header_addr=0.

Configuration
REQ-032 With JFPJC_FRAMER_BYTESTUFF_EN defined, stuffing SHALL follow REQ-023; without it, FIFO bytes SHALL pass unmodified and stuff_pending SHALL be absent.

Verification
REQ-033 HEADER_LEN=4, ROM {FF,D8,12,34}, out_ready=1, frame_start -> outputs FF D8 12 34, one byte every 2 cycles, then SCAN.
REQ-034 SCAN, comp bytes 12,FF,34 -> outputs 12 FF 00 34 with macro, 12 FF 34 without.
REQ-035 out_ready=0, 17 comp bytes in SCAN (FIFO_DEPTH=16) -> overflow=1; after out_ready=1, first 16 bytes emitted in order, 17th absent.
REQ-036 frame_end with 2 bytes (AA,BB) queued -> outputs AA BB FF D9, one-cycle frame_done, busy=0 the cycle after.
REQ-037 frame_start pulsed during SCAN -> no effect on state or stream.
REQ-038 nreset low mid-SCAN with queued data -> out_valid=0 asynchronously, all outputs 0; the next frame emits header from address 0, overflow=0.
